counter_sequencer: RTL and testbench

- Control block for the on-board up-counter datapath.
- Turns three raw push-button inputs (run/stop, single-step, clear) into clean one-cycle enable and clear strobes for the counter register.
- Generates the counter's application tick from the 16 MHz board clock with a fractional accumulator, so the counter runs in the main clock domain instead of on a derived clock.
- Sits between the board pins and the counter register inside top.

---
 rtl/counter_sequencer.sv | 159 +++++++++++++++
 tb/tb_counter_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Button-driven run/step/clear sequencer for the up-counter, with fractional-rate tick.
// Optional auto-stop at cnt_limit is enabled by defining COUNTER_SEQUENCER_AUTO_STOP_EN.
module counter_sequencer #(
  parameter int CLK_HZ    = 16_000_000,
  parameter int TICK_HZ   = 10,
  parameter int DB_CYCLES = 160_000,
  parameter int CW        = 8
) (
  input  logic          pin3_clk_16mhz,
  input  logic          reset_n,
  input  logic          btn_run,
  input  logic          btn_step,
  input  logic          btn_clear,
  input  logic [CW-1:0] cnt_value,
  input  logic [CW-1:0] cnt_limit,
  output logic          cnt_en,
  output logic          cnt_clr,
  output logic          running,
  output logic          done
);

  localparam int             DBW     = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_MAX  = DBW'(DB_CYCLES);
  localparam logic [31:0]    ACC_INC = 32'(TICK_HZ);
  localparam logic [31:0]    ACC_MOD = 32'(CLK_HZ);

  typedef enum logic [1:0] {STOPPED, RUNNING, STEP} state_t;

  // Bit 0 = run, bit 1 = step, bit 2 = clear
  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q, db_q, db_prev_q, press_q;
  logic [DBW-1:0] db_cnt_q [3];
  logic           run_p, step_p, clr_p;

  assign btn_raw = {btn_clear, btn_step, btn_run};
  assign run_p   = press_q[0];
  assign step_p  = press_q[1];
  assign clr_p   = press_q[2];

  always_ff @(posedge pin3_clk_16mhz) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      press_q   <= db_q & ~db_prev_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_MAX) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Fractional accumulator: long-run tick rate is exactly TICK_HZ/CLK_HZ per cycle
  logic [31:0] acc_q, acc_sum_d, acc_d;
  logic        tick_d, tick_q;

  assign acc_sum_d = acc_q + ACC_INC;
  assign tick_d    = (acc_sum_d >= ACC_MOD);
  assign acc_d     = tick_d ? (acc_sum_d - ACC_MOD) : acc_sum_d;

`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
  logic at_limit, done_q;
  assign at_limit = (cnt_value == cnt_limit);
  assign done     = done_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_value, cnt_limit};
  assign done       = 1'b0;
`endif

  state_t state_q;
  logic   en_q, clr_q, running_q;

  always_ff @(posedge pin3_clk_16mhz) begin
    if (!reset_n) begin
      state_q   <= STOPPED;
      acc_q     <= '0;
      tick_q    <= 1'b0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
      done_q    <= 1'b0;
`endif
    end else begin
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      tick_q <= 1'b0;
`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
      done_q <= 1'b0;
`endif
      // Clear outranks run, which outranks step/tick; a coincident lower-priority event is dropped
      case (state_q)
        STOPPED, STEP: begin
          acc_q <= '0;
          if (clr_p) begin
            clr_q     <= 1'b1;
            state_q   <= STOPPED;
            running_q <= 1'b0;
          end else if (run_p) begin
            state_q   <= RUNNING;
            running_q <= 1'b1;
          end else if (step_p && state_q == STOPPED) begin
            state_q   <= STEP;
            en_q      <= 1'b1;
            running_q <= 1'b0;
          end else begin
            state_q   <= STOPPED;
            running_q <= 1'b0;
          end
        end
        RUNNING: begin
          acc_q  <= acc_d;
          tick_q <= tick_d;
          if (clr_p) begin
            clr_q <= 1'b1;
          end else if (run_p) begin
            state_q   <= STOPPED;
            running_q <= 1'b0;
          end else if (tick_q) begin
`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
            if (at_limit) begin
              done_q    <= 1'b1;
              state_q   <= STOPPED;
              running_q <= 1'b0;
            end else begin
              en_q <= 1'b1;
            end
`else
            en_q <= 1'b1;
`endif
          end
        end
        default: begin
          state_q   <= STOPPED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en  = en_q;
  assign cnt_clr = clr_q;
  assign running = running_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer (CLK_HZ=20, TICK_HZ=2, DB_CYCLES=4, CW=8).
// Expected strobes are queued with their cycle when the stimulus is driven.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn_run, btn_step, btn_clear;
  logic [7:0] cnt_value = 8'd0;
  logic [7:0] cnt_limit;
  logic       cnt_en, cnt_clr, running, done;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  localparam int K_EN   = 1;
  localparam int K_CLR  = 2;
  localparam int K_DONE = 4;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  int  mon_obs;

  counter_sequencer #(
    .CLK_HZ(20), .TICK_HZ(2), .DB_CYCLES(4), .CW(8)
  ) dut (
    .pin3_clk_16mhz(clk),
    .reset_n(reset_n),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .btn_clear(btn_clear),
    .cnt_value(cnt_value),
    .cnt_limit(cnt_limit),
    .cnt_en(cnt_en),
    .cnt_clr(cnt_clr),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: the counter register fed by the strobes
  always @(posedge clk) begin
    if (cnt_clr) cnt_value <= 8'd0;
    else if (cnt_en) cnt_value <= cnt_value + 8'd1;
  end

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_running(input int t, input int expv);
    wait_cyc(t);
    @(negedge clk);
    check($sformatf("running@%0d", t), int'(running), expv);
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon_obs = {29'd0, done, cnt_clr, cnt_en};
      if (mon_obs != 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", mon_obs, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", mon_obs, mon_e.kind);
          check("strobe_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected end by 430", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    btn_run   = 1'b0;
    btn_step  = 1'b0;
    btn_clear = 1'b0;
    cnt_limit = 8'hFF;

    wait_cyc(3);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_cnt_en", int'(cnt_en), 0);
    check("rst_cnt_clr", int'(cnt_clr), 0);
    check("rst_running", int'(running), 0);
    check("rst_done", int'(done), 0);
    started = 1'b1;

    // Idle: no strobes at all
    check_running(110, 0);

    // Two single steps while stopped
    wait_cyc(120); btn_step = 1'b1; push(K_EN, 129);
    wait_cyc(128); btn_step = 1'b0;
    wait_cyc(136); btn_step = 1'b1; push(K_EN, 145);
    wait_cyc(144); btn_step = 1'b0;
    check_running(150, 0);

    // Bouncing run press, steady from 164 -> running from 173
    wait_cyc(160); btn_run = 1'b1;
    push(K_EN, 184); push(K_EN, 194); push(K_EN, 204);
    push(K_CLR, 214); push(K_EN, 224); push(K_EN, 234);
    wait_cyc(161); btn_run = 1'b0;
    wait_cyc(162); btn_run = 1'b1;
    wait_cyc(163); btn_run = 1'b0;
    wait_cyc(164); btn_run = 1'b1;
    check_running(172, 0);
    check_running(173, 1);
    wait_cyc(174); btn_run = 1'b0;
    // Step while running is ignored
    wait_cyc(187); btn_step = 1'b1;
    wait_cyc(195); btn_step = 1'b0;
    // Clear press lands on the tick at 213
    wait_cyc(205); btn_clear = 1'b1;
    wait_cyc(213); btn_clear = 1'b0;
    check_running(220, 1);
    // Stop
    wait_cyc(228); btn_run = 1'b1;
    check_running(236, 1);
    check_running(237, 0);
    wait_cyc(238); btn_run = 1'b0;

    // Limit phase: clear the counter, set limit 3, run
    wait_cyc(250); btn_clear = 1'b1; push(K_CLR, 259);
    wait_cyc(258); btn_clear = 1'b0;
    wait_cyc(260); cnt_limit = 8'd3;
    wait_cyc(270); btn_run = 1'b1;
    push(K_EN, 290); push(K_EN, 300); push(K_EN, 310);
`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
    push(K_DONE, 320);
`else
    push(K_EN, 320); push(K_EN, 330);
`endif
    wait_cyc(278); btn_run = 1'b0;
    check_running(279, 1);
`ifdef COUNTER_SEQUENCER_AUTO_STOP_EN
    check_running(319, 1);
    check_running(320, 0);
    wait_cyc(350);
    check("cnt_value_at_stop", int'(cnt_value), 3);
`else
    wait_cyc(324); btn_run = 1'b1;
    check_running(332, 1);
    check_running(333, 0);
    wait_cyc(334); btn_run = 1'b0;
    wait_cyc(350);
    check("cnt_value_past_limit", int'(cnt_value), 5);
`endif

    // Reset while running: no tick strobe afterwards
    wait_cyc(380); btn_run = 1'b1;
    wait_cyc(388); btn_run = 1'b0;
    check_running(389, 1);
    wait_cyc(392); reset_n = 1'b0;
    wait_cyc(393); reset_n = 1'b1;
    check_running(393, 0);
    check("midrst_cnt_en", int'(cnt_en), 0);

    wait_cyc(430);
    @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    check("final_running", int'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
